// File: rtl/prbs_chk_pkg.sv
// ---------------------------------------------------------------------------
// prbs_chk_pkg
//   Shared types and helpers for the PRBS stream checker.
//   - chk_state_t : checker FSM states (HUNT, SYNC, LOCKED)
//   - LFSR_ZERO   : the LFSR lock-up value; never a legal sequence word
//   - lfsr64_next : one step of the x^64 LFSR used by the stimulus generator
//                   next = {d[62:0], d[63] ^ d[2] ^ d[0]}
// ---------------------------------------------------------------------------
package prbs_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam logic [63:0] LFSR_ZERO = 64'h0;

    function automatic logic [63:0] lfsr64_next(input logic [63:0] d);
        return {d[62:0], d[63] ^ d[2] ^ d[0]};
    endfunction

endpackage

// File: rtl/prbs_stream_checker_misr64.sv
// ---------------------------------------------------------------------------
// misr64
//   64-bit multiple-input signature register. Each enabled cycle folds din
//   into the signature: sig <= din ^ lfsr64_next(sig). Generic enough to be
//   reused by other harnesses.
// Ports
//   clk    in   1   clock, state on posedge
//   reset  in   1   synchronous, active-high; clears the signature
//   en     in   1   fold din this cycle
//   din    in   64  data word to compress
//   sig    out  64  current signature (registered)
// ---------------------------------------------------------------------------
module misr64
    import prbs_chk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] din,
    output logic [63:0] sig
);

    logic [63:0] sig_q;
    logic [63:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (en) begin
            sig_d = din ^ lfsr64_next(sig_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/prbs_stream_checker.sv
// ---------------------------------------------------------------------------
// prbs_stream_checker
//   Receive-side checker for the x^64 LFSR word stream. Hunts for a nonzero
//   seed word, confirms SYNC_COUNT consecutive correct predictions, then
//   flywheels its own prediction while LOCKED, counting mismatches and
//   compressing accepted words into a MISR signature. LOSS_COUNT consecutive
//   mismatches drop lock back to HUNT.
//
// Parameters
//   SYNC_COUNT  consecutive matches needed to lock (>=1)
//   LOSS_COUNT  consecutive LOCKED mismatches that drop lock (>=1)
//   ERR_W       width of the saturating error counter
//
// Ports
//   clk         in   1      clock, all state on posedge
//   reset       in   1      synchronous, active-high
//   in_valid    in   1      in_data valid this cycle (no backpressure)
//   in_data     in   64     received word
//   locked      out  1      registered; 1 while state is LOCKED
//   err_count   out  ERR_W  LOCKED mismatches, saturating
//   word_count  out  32     words accepted while LOCKED, wraps
//   signature   out  64     MISR over words accepted while LOCKED
//
// Optional feature (macro PRBS_CHK_FIRST_ERR_EN):
//   first_err_valid out 1   sticky flag set by the first LOCKED mismatch
//   first_err_data  out 64  in_data of that first mismatch, sticky
// ---------------------------------------------------------------------------
module prbs_stream_checker
    import prbs_chk_pkg::*;
#(
    parameter int SYNC_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             locked,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      word_count,
    output logic [63:0]      signature
`ifdef PRBS_CHK_FIRST_ERR_EN
    ,
    output logic             first_err_valid,
    output logic [63:0]      first_err_data
`endif
);

    localparam int MCW = $clog2(SYNC_COUNT + 1);
    localparam int LCW = $clog2(LOSS_COUNT + 1);

    chk_state_t       state_q,      state_d;
    logic [63:0]      pred_q,       pred_d;
    logic [MCW-1:0]   match_cnt_q,  match_cnt_d;
    logic [LCW-1:0]   miss_cnt_q,   miss_cnt_d;
    logic [ERR_W-1:0] err_count_q,  err_count_d;
    logic [31:0]      word_count_q, word_count_d;
    logic             locked_q,     locked_d;

    logic             word_hit;
    logic             misr_en;

`ifdef PRBS_CHK_FIRST_ERR_EN
    logic             fe_valid_q, fe_valid_d;
    logic [63:0]      fe_data_q,  fe_data_d;
`endif

    assign word_hit = (in_data == pred_q);
    assign misr_en  = in_valid && (state_q == LOCKED);

    always_comb begin
        state_d      = state_q;
        pred_d       = pred_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
`ifdef PRBS_CHK_FIRST_ERR_EN
        fe_valid_d   = fe_valid_q;
        fe_data_d    = fe_data_q;
`endif
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // The all-zero word is the LFSR lock-up state and can
                    // never seed a valid sequence.
                    if (in_data != LFSR_ZERO) begin
                        pred_d      = lfsr64_next(in_data);
                        match_cnt_d = '0;
                        state_d     = SYNC;
                    end
                end
                SYNC: begin
                    if (in_data == LFSR_ZERO) begin
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end else begin
                        // Always follow received data while syncing; only
                        // the match counter depends on the comparison.
                        pred_d = lfsr64_next(in_data);
                        if (!word_hit) begin
                            match_cnt_d = '0;
                        end else if (match_cnt_q == MCW'(SYNC_COUNT - 1)) begin
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            state_d     = LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances from itself so a burst
                    // of bad words cannot corrupt the reference.
                    pred_d       = lfsr64_next(pred_q);
                    word_count_d = word_count_q + 32'd1;
                    if (word_hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
`ifdef PRBS_CHK_FIRST_ERR_EN
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_data_d  = in_data;
                        end
`endif
                        if (miss_cnt_q == LCW'(LOSS_COUNT - 1)) begin
                            miss_cnt_d = '0;
                            state_d    = HUNT;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            pred_q       <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            err_count_q  <= '0;
            word_count_q <= '0;
            locked_q     <= 1'b0;
`ifdef PRBS_CHK_FIRST_ERR_EN
            fe_valid_q   <= 1'b0;
            fe_data_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            locked_q     <= locked_d;
`ifdef PRBS_CHK_FIRST_ERR_EN
            fe_valid_q   <= fe_valid_d;
            fe_data_q    <= fe_data_d;
`endif
        end
    end

    misr64 u_misr (
        .clk   (clk),
        .reset (reset),
        .en    (misr_en),
        .din   (in_data),
        .sig   (signature)
    );

    assign locked     = locked_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
`ifdef PRBS_CHK_FIRST_ERR_EN
    assign first_err_valid = fe_valid_q;
    assign first_err_data  = fe_data_q;
`endif

endmodule

// File: tb/tb_prbs_stream_checker.sv
// ---------------------------------------------------------------------------
// Bench for prbs_stream_checker. Main instance uses default parameters and
// is checked by a scoreboard fed from a behavioural model; a second instance
// (SYNC_COUNT=1, large LOSS_COUNT) exercises error-counter saturation.
// ---------------------------------------------------------------------------
module tb_prbs_stream_checker;

    localparam logic [63:0] SEED  = 64'h5aef0c8d_d70a4497;
    localparam logic [63:0] W98   = 64'hc77bb9b3_784ea091;

    logic        clk = 1'b0;
    logic        rst = 1'b1, vld = 1'b0;
    logic [63:0] dat = '0;
    logic        rst2 = 1'b1, vld2 = 1'b0;
    logic [63:0] dat2 = '0;

    logic        locked,  locked2;
    logic [15:0] err,     err2;
    logic [31:0] wcnt,    wcnt2;
    logic [63:0] sig,     sig2;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic        fev,  fev2;
    logic [63:0] fed,  fed2;
`endif

    always #5 clk = ~clk;

    prbs_stream_checker dut (
        .clk(clk), .reset(rst), .in_valid(vld), .in_data(dat),
        .locked(locked), .err_count(err), .word_count(wcnt), .signature(sig)
`ifdef PRBS_CHK_FIRST_ERR_EN
        , .first_err_valid(fev), .first_err_data(fed)
`endif
    );

    prbs_stream_checker #(.SYNC_COUNT(1), .LOSS_COUNT(200000), .ERR_W(16)) dut2 (
        .clk(clk), .reset(rst2), .in_valid(vld2), .in_data(dat2),
        .locked(locked2), .err_count(err2), .word_count(wcnt2), .signature(sig2)
`ifdef PRBS_CHK_FIRST_ERR_EN
        , .first_err_valid(fev2), .first_err_data(fed2)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] nx(input logic [63:0] d);
        logic [63:0] r;
        r = d << 1;
        r[0] = d[63] ^ d[2] ^ d[0];
        return r;
    endfunction

    // ---------------- behavioural model + scoreboard ----------------
    typedef struct {
        logic        lk;
        logic [15:0] er;
        logic [31:0] wc;
        logic [63:0] sg;
        logic        fv;
        logic [63:0] fd;
    } exp_t;

    exp_t sb[$];

    int          m_state = 0;   // 0 hunt, 1 sync, 2 locked
    int          m_match = 0, m_miss = 0, m_err = 0;
    logic [63:0] m_pred = '0, m_sig = '0, m_fd = '0;
    logic [31:0] m_wc = '0;
    logic        m_fv = 1'b0;

    task automatic model(input logic r, input logic v, input logic [63:0] d);
        exp_t e;
        if (r) begin
            m_state = 0; m_match = 0; m_miss = 0; m_err = 0;
            m_pred = '0; m_sig = '0; m_wc = '0; m_fv = 1'b0; m_fd = '0;
        end else if (v) begin
            if (m_state == 0) begin
                if (d != 64'd0) begin
                    m_pred = nx(d); m_match = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == 64'd0) begin
                    m_state = 0; m_match = 0;
                end else begin
                    if (d == m_pred) m_match++;
                    else             m_match = 0;
                    m_pred = nx(d);
                    if (m_match >= 4) begin
                        m_state = 2; m_match = 0; m_miss = 0;
                    end
                end
            end else begin
                m_wc  = m_wc + 1;
                m_sig = d ^ nx(m_sig);
                if (d == m_pred) m_miss = 0;
                else begin
                    if (m_err < 65535) m_err++;
                    if (!m_fv) begin m_fv = 1'b1; m_fd = d; end
                    m_miss++;
                    if (m_miss >= 3) begin m_state = 0; m_miss = 0; end
                end
                m_pred = nx(m_pred);
            end
        end
        e.lk = (m_state == 2); e.er = 16'(m_err); e.wc = m_wc;
        e.sg = m_sig; e.fv = m_fv; e.fd = m_fd;
        sb.push_back(e);
    endtask

    // Drive one cycle on the main instance and queue its expected outcome.
    task automatic step(input logic r, input logic v, input logic [63:0] d);
        @(negedge clk);
        rst = r; vld = v; dat = d;
        model(r, v, d);
    endtask

    task automatic after_edge;
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs reflect the word sampled on the preceding edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("locked",     {63'd0, locked}, {63'd0, e.lk});
                chk("err_count",  {48'd0, err},    {48'd0, e.er});
                chk("word_count", {32'd0, wcnt},   {32'd0, e.wc});
                chk("signature",  sig,             e.sg);
`ifdef PRBS_CHK_FIRST_ERR_EN
                chk("first_err_valid", {63'd0, fev}, {63'd0, e.fv});
                chk("first_err_data",  fed,          e.fd);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] g;
        logic [63:0] w;
        logic [63:0] first_bad;

        // 1: reset, lock, long clean run
        step(1, 0, '0);
        step(1, 0, '0);
        after_edge();
        chk("reset_locked", {63'd0, locked}, 64'd0);
        chk("reset_sig",    sig,             64'd0);
        g = SEED;
        for (int i = 0; i < 100; i++) begin
            w = (i == 98) ? W98 : g;
            step(0, 1, w);
            g = nx(g);
            if (i == 3) begin after_edge(); chk("not_locked_4th", {63'd0, locked}, 64'd0); end
            if (i == 4) begin after_edge(); chk("locked_5th", {63'd0, locked}, 64'd1); end
        end
        after_edge();
        chk("clean_err", {48'd0, err}, 64'd0);
        chk("word98_locked", {63'd0, locked}, 64'd1);
        chk("clean_wcnt", {32'd0, wcnt}, 64'd95);

        // 2: single bit-0 flip, then flywheel match
        step(0, 1, g ^ 64'd1); g = nx(g);
        after_edge();
        chk("single_err", {48'd0, err}, 64'd1);
        chk("single_lock", {63'd0, locked}, 64'd1);
        step(0, 1, g); g = nx(g);
        step(0, 0, '0);
        step(0, 1, g); g = nx(g);

        // 3: three consecutive bad words drop lock
        for (int k = 0; k < 3; k++) begin
            step(0, 1, g ^ (64'h8000_0000_0000_0000 >> k)); g = nx(g);
            if (k == 1) begin after_edge(); chk("still_lock_2bad", {63'd0, locked}, 64'd1); end
        end
        after_edge();
        chk("lost_lock", {63'd0, locked}, 64'd0);
        chk("loss_err", {48'd0, err}, 64'd4);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, g); g = nx(g);
            if (i == 3) begin after_edge(); chk("relock_wait", {63'd0, locked}, 64'd0); end
        end
        after_edge();
        chk("relock", {63'd0, locked}, 64'd1);

        // 4: zero word in HUNT, then idle cycles
        step(1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 64'd0);
        for (int i = 0; i < 20; i++) step(0, 0, 64'hdead_beef_0000_0001);
        after_edge();
        chk("zero_hunt_lock", {63'd0, locked}, 64'd0);
        chk("idle_wcnt", {32'd0, wcnt}, 64'd0);
        // zero word during SYNC returns to HUNT; a 4-match run after it is not enough
        g = SEED;
        step(0, 1, g); g = nx(g);
        step(0, 1, g); g = nx(g);
        step(0, 1, 64'd0);
        for (int i = 0; i < 4; i++) begin step(0, 1, g); g = nx(g); end
        after_edge();
        chk("zero_in_sync", {63'd0, locked}, 64'd0);

        // 5: lock with gaps, reset mid-lock, relock
        for (int i = 0; i < 6; i++) begin
            step(0, 1, g); g = nx(g);
            step(0, 0, '0);
        end
        after_edge();
        chk("gap_lock", {63'd0, locked}, 64'd1);
        step(1, 1, g); g = nx(g);
        after_edge();
        chk("midreset_lock", {63'd0, locked}, 64'd0);
        chk("midreset_wcnt", {32'd0, wcnt}, 64'd0);
        chk("midreset_sig", sig, 64'd0);
        for (int i = 0; i < 7; i++) begin step(0, 1, g); g = nx(g); end
        after_edge();
        chk("post_reset_relock", {63'd0, locked}, 64'd1);
        step(0, 0, '0);

        // 6: saturation on the SYNC_COUNT=1 instance
        @(negedge clk); rst2 = 1'b1; vld2 = 1'b0;
        @(negedge clk); rst2 = 1'b0; vld2 = 1'b1; dat2 = SEED; g = nx(SEED);
        @(negedge clk); dat2 = g; g = nx(g);
        after_edge();
        chk("sat_lock1", {63'd0, locked2}, 64'd1);
        first_bad = g ^ 64'h0000_0001_0000_0000;
        for (int n = 1; n <= 65537; n++) begin
            @(negedge clk);
            dat2 = (n == 1) ? first_bad : (g ^ 64'd1);
            g = nx(g);
            if (n == 65534) begin after_edge(); chk("sat_near", {48'd0, err2}, 64'h0000_0000_0000_fffe); end
        end
        @(negedge clk); vld2 = 1'b0;
        after_edge();
        chk("sat_err", {48'd0, err2}, 64'h0000_0000_0000_ffff);
        chk("sat_still_locked", {63'd0, locked2}, 64'd1);
        chk("sat_wcnt", {32'd0, wcnt2}, 64'd65537);
`ifdef PRBS_CHK_FIRST_ERR_EN
        chk("sat_first_err", fed2, first_bad);
`endif

        after_edge();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
